uart_tx_arbiter: RTL



---
 rtl/uart_tx_arbiter.sv | 117 +++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin owner selection for a single shared UART transmitter.
// An owner keeps the transmitter for up to MAX_BURST bytes or until it flags Last.
module uart_tx_arbiter #(
  parameter int N         = 4,
  parameter int MAX_BURST = 16
) (
  input  logic           Clock,
  input  logic           Reset,
  input  logic [N-1:0]   Req,
  input  logic [8*N-1:0] Data,
  input  logic [N-1:0]   Last,
  output logic [N-1:0]   Ack,
  output logic [N-1:0]   Grant,
  output logic           Busy,
  output logic           TxInit,
  output logic [7:0]     TxData,
  input  logic           TxDone
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = $clog2(MAX_BURST + 1);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] SEND      = 2'd1;
  localparam logic [1:0] WAIT_BUSY = 2'd2;
  localparam logic [1:0] WAIT_DONE = 2'd3;

  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

  logic [1:0]    state;
  logic [PW-1:0] ptr;
  logic [PW-1:0] owner;
  logic [PW-1:0] winner;
  logic [PW-1:0] cand;
  logic          found;
  logic [CW-1:0] count;
  logic          last_r;
  logic          more;
  int            idx;

  // Search ptr, ptr+1, ... wrapping at N; first requester found wins.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    cand   = '0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      cand = PW'(idx);
      if (!found && Req[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  assign more = Req[owner] && !last_r && (count < CW'(MAX_BURST));

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state  <= IDLE;
      ptr    <= '0;
      owner  <= '0;
      Grant  <= '0;
      Ack    <= '0;
      TxInit <= 1'b0;
      TxData <= 8'h00;
      Busy   <= 1'b0;
      count  <= '0;
      last_r <= 1'b0;
    end else begin
      Ack    <= '0;
      // TxInit is the registered image of SEND, so it lands one cycle after SEND is entered.
      TxInit <= (state == SEND);
      case (state)
        IDLE: begin
          if (found) begin
            owner  <= winner;
            Grant  <= ONE << winner;
            Ack    <= ONE << winner;
            TxData <= Data[8*int'(winner) +: 8];
            last_r <= Last[winner];
            count  <= CW'(1);
            ptr    <= (winner == PW'(N-1)) ? '0 : winner + 1'b1;
            state  <= SEND;
            Busy   <= 1'b1;
          end
        end
        SEND: state <= WAIT_BUSY;
        WAIT_BUSY: begin
          if (!TxDone) state <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (TxDone) begin
            if (more) begin
              TxData <= Data[8*int'(owner) +: 8];
              last_r <= Last[owner];
              Ack    <= ONE << owner;
              count  <= count + 1'b1;
              state  <= SEND;
            end else begin
              Grant <= '0;
              state <= IDLE;
              Busy  <= 1'b0;
            end
          end
        end
        default: begin
          state <= IDLE;
          Busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
